// File: rtl/hifp_local_mem_responder.sv
// Avalon-MM burst slave backed by on-chip RAM; terminates one HLS kernel LSU port.
// Bursts are serialised by a small FSM, and read beats return through a fixed-latency pipeline.
module hifp_local_mem_responder #(
  parameter int DATA_W  = 512,
  parameter int ADDR_W  = 32,
  parameter int BURST_W = 5,
  parameter int DEPTH   = 1024,
  parameter int RD_LAT  = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     avs_address,
  input  logic                  avs_read,
  input  logic                  avs_write,
  input  logic [DATA_W-1:0]     avs_writedata,
  input  logic [DATA_W/8-1:0]   avs_byteenable,
  input  logic [BURST_W-1:0]    avs_burstcount,
  output logic                  avs_waitrequest,
  output logic [DATA_W-1:0]     avs_readdata,
  output logic                  avs_readdatavalid,
  output logic                  avs_writeack,
  output logic                  busy,
  output logic                  protocol_err
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] RD_BURST = 2'd1;
  localparam logic [1:0] WR_BURST = 2'd2;

  logic [1:0]         state;
  logic [IDX_W-1:0]   cmd_idx;
  logic [IDX_W-1:0]   ptr;
  logic [BURST_W-1:0] remaining;
  logic               bc_legal;
  logic [BURST_W-1:0] bc_eff;
  logic               rd_issue;
  logic [IDX_W-1:0]   rd_idx;
  logic               wr_commit;
  logic [IDX_W-1:0]   wr_idx;
  logic               writeack_q;

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [DATA_W-1:0]  pipe_data [RD_LAT];
  logic [RD_LAT-1:0]  pipe_valid;

  logic unused_addr;
  assign unused_addr = ^{avs_address[OFF_W-1:0], avs_address[ADDR_W-1:OFF_W+IDX_W]};

  assign cmd_idx  = avs_address[OFF_W +: IDX_W];
  assign bc_legal = (avs_burstcount != '0) && (avs_burstcount <= BURST_W'(16));
  assign bc_eff   = bc_legal ? avs_burstcount : BURST_W'(1);

  // Reset forces waitrequest high immediately so no command sneaks in while the FSM is held.
  assign avs_waitrequest   = reset || (state == RD_BURST);
  assign avs_readdata      = pipe_data[RD_LAT-1];
  assign avs_readdatavalid = pipe_valid[RD_LAT-1];
  assign avs_writeack      = writeack_q;
  assign busy              = (state != IDLE) || (|pipe_valid);

  always_comb begin
    rd_issue  = 1'b0;
    rd_idx    = cmd_idx;
    wr_commit = 1'b0;
    wr_idx    = cmd_idx;
    case (state)
      IDLE: begin
        if (avs_write)      wr_commit = 1'b1;
        else if (avs_read)  rd_issue  = 1'b1;
      end
      RD_BURST: begin
        rd_issue = 1'b1;
        rd_idx   = ptr;
      end
      WR_BURST: begin
        wr_commit = avs_write;
        wr_idx    = ptr;
      end
      default: ;
    endcase
  end

  // Burst sequencing; ptr holds the word for the next beat, remaining counts beats still to go.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      ptr          <= '0;
      remaining    <= '0;
      writeack_q   <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      writeack_q <= 1'b0;
      case (state)
        IDLE: begin
          if (avs_write) begin
            if (avs_read || !bc_legal) protocol_err <= 1'b1;
            if (bc_eff == BURST_W'(1)) begin
              writeack_q <= 1'b1;
            end else begin
              ptr       <= cmd_idx + IDX_W'(1);
              remaining <= bc_eff - BURST_W'(1);
              state     <= WR_BURST;
            end
          end else if (avs_read) begin
            if (!bc_legal) protocol_err <= 1'b1;
            if (bc_eff != BURST_W'(1)) begin
              ptr       <= cmd_idx + IDX_W'(1);
              remaining <= bc_eff - BURST_W'(1);
              state     <= RD_BURST;
            end
          end
        end
        RD_BURST: begin
          ptr       <= ptr + IDX_W'(1);
          remaining <= remaining - BURST_W'(1);
          if (remaining == BURST_W'(1)) state <= IDLE;
        end
        WR_BURST: begin
          if (avs_read) protocol_err <= 1'b1;
          if (avs_write) begin
            ptr       <= ptr + IDX_W'(1);
            remaining <= remaining - BURST_W'(1);
            if (remaining == BURST_W'(1)) begin
              writeack_q <= 1'b1;
              state      <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM is deliberately not reset so contents survive a reset pulse.
  always_ff @(posedge clock) begin
    if (wr_commit) begin
      for (int b = 0; b < BE_W; b++) begin
        if (avs_byteenable[b]) mem[wr_idx][b*8 +: 8] <= avs_writedata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pipe_valid <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_data[i] <= '0;
    end else begin
      pipe_valid[0] <= rd_issue;
      pipe_data[0]  <= mem[rd_idx];
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_data[i]  <= pipe_data[i-1];
      end
    end
  end

endmodule

// File: tb/tb_hifp_local_mem_responder.sv
// Scoreboard bench: tasks push expected read beats and write acks with their due cycle,
// and a negedge monitor pops and compares whenever the DUT presents one.
module tb_hifp_local_mem_responder;

  localparam int DATA_W  = 512;
  localparam int ADDR_W  = 32;
  localparam int BURST_W = 5;
  localparam int DEPTH   = 1024;
  localparam int RD_LAT  = 2;
  localparam int BE_W    = DATA_W / 8;

  typedef logic [DATA_W-1:0] word_t;
  typedef struct { word_t data; int cycle; } exp_t;

  logic                clock;
  logic                reset;
  logic [ADDR_W-1:0]   avs_address;
  logic                avs_read;
  logic                avs_write;
  word_t               avs_writedata;
  logic [BE_W-1:0]     avs_byteenable;
  logic [BURST_W-1:0]  avs_burstcount;
  logic                avs_waitrequest;
  word_t               avs_readdata;
  logic                avs_readdatavalid;
  logic                avs_writeack;
  logic                busy;
  logic                protocol_err;

  word_t model [DEPTH];
  exp_t  rd_q[$];
  int    ack_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  exp_t  mon_e;
  int    mon_c;

  hifp_local_mem_responder #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_W(BURST_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)
  ) dut (
    .clock(clock), .reset(reset),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
    .avs_burstcount(avs_burstcount), .avs_waitrequest(avs_waitrequest),
    .avs_readdata(avs_readdata), .avs_readdatavalid(avs_readdatavalid),
    .avs_writeack(avs_writeack), .busy(busy), .protocol_err(protocol_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic word_t pat(input logic [31:0] s);
    word_t w;
    for (int i = 0; i < DATA_W/32; i++) w[i*32 +: 32] = s + 32'(i * 32'h0101_0101);
    return w;
  endfunction

  task automatic check_output(input string name, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every returned beat or ack must match the head of its queue, including the cycle.
  always @(negedge clock) begin
    if (!reset) begin
      if (avs_readdatavalid) begin
        if (rd_q.size() == 0) begin
          check_output("unexpected_readdatavalid", word_t'(1), word_t'(0));
        end else begin
          mon_e = rd_q.pop_front();
          check_output("readdata", avs_readdata, mon_e.data);
          check_output("readdata_cycle", word_t'(cyc), word_t'(mon_e.cycle));
        end
      end
      if (avs_writeack) begin
        if (ack_q.size() == 0) begin
          check_output("unexpected_writeack", word_t'(1), word_t'(0));
        end else begin
          mon_c = ack_q.pop_front();
          check_output("writeack_cycle", word_t'(cyc), word_t'(mon_c));
        end
      end
    end
  end

  function automatic int beats(input logic [BURST_W-1:0] bc);
    return (bc == 0 || bc > 16) ? 1 : int'(bc);
  endfunction

  task automatic write_burst(input logic [ADDR_W-1:0] addr, input logic [BURST_W-1:0] bc,
                             input logic [31:0] seed, input logic [BE_W-1:0] be,
                             input int gap_after, input logic read_too);
    int idx = int'(addr >> 6) % DEPTH;
    int n = beats(bc);
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      avs_write      = 1'b1;
      avs_read       = (k == 0) && read_too;
      avs_address    = (k == 0) ? addr : 32'hDEAD_BEEF;
      avs_burstcount = (k == 0) ? bc : 5'd0;
      avs_writedata  = pat(seed + 32'(k));
      avs_byteenable = be;
      check_output("wr_waitrequest", word_t'(avs_waitrequest), word_t'(0));
      for (int b = 0; b < BE_W; b++)
        if (be[b]) model[(idx + k) % DEPTH][b*8 +: 8] = avs_writedata[b*8 +: 8];
      if (k == n - 1) ack_q.push_back(cyc + 1);
      if (k == gap_after) begin
        @(negedge clock);
        avs_write = 1'b0;
        avs_read  = 1'b0;
      end
    end
    @(negedge clock);
    avs_write = 1'b0;
    avs_read  = 1'b0;
  endtask

  task automatic read_burst(input logic [ADDR_W-1:0] addr, input logic [BURST_W-1:0] bc);
    int idx = int'(addr >> 6) % DEPTH;
    int n = beats(bc);
    exp_t e;
    @(negedge clock);
    avs_read       = 1'b1;
    avs_address    = addr;
    avs_burstcount = bc;
    check_output("rd_cmd_waitrequest", word_t'(avs_waitrequest), word_t'(0));
    for (int k = 0; k < n; k++) begin
      e.data  = model[(idx + k) % DEPTH];
      e.cycle = cyc + k + RD_LAT;
      rd_q.push_back(e);
    end
    for (int k = 1; k < n; k++) begin
      @(negedge clock);
      avs_read       = 1'b0;
      avs_burstcount = 5'd0;
      check_output("rd_burst_waitrequest", word_t'(avs_waitrequest), word_t'(1));
      check_output("rd_burst_busy", word_t'(busy), word_t'(1));
    end
    @(negedge clock);
    avs_read = 1'b0;
    check_output("rd_done_waitrequest", word_t'(avs_waitrequest), word_t'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_waitrequest"}, word_t'(avs_waitrequest), word_t'(1));
    check_output({tag, "_readdatavalid"}, word_t'(avs_readdatavalid), word_t'(0));
    check_output({tag, "_writeack"}, word_t'(avs_writeack), word_t'(0));
    check_output({tag, "_busy"}, word_t'(busy), word_t'(0));
  endtask

  initial begin
    exp_t e;
    int   c;
    reset = 1'b1;
    avs_address = '0; avs_read = 1'b0; avs_write = 1'b0;
    avs_writedata = '0; avs_byteenable = '0; avs_burstcount = '0;

    repeat (2) @(negedge clock);
    check_reset_outputs("reset");
    check_output("reset_readdata", avs_readdata, '0);
    check_output("reset_protocol_err", word_t'(protocol_err), word_t'(0));
    @(negedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check_output("post_reset_waitrequest", word_t'(avs_waitrequest), word_t'(0));

    // 4-beat write A..D at 0x40, then read it back
    write_burst(32'h40, 5'd4, 32'hA000_0000, '1, -1, 1'b0);
    read_burst(32'h40, 5'd4);

    // Partial byteenable at word 5 (offset bits in the address must be ignored)
    write_burst(32'h140, 5'd1, 32'hE000_0000, '1, -1, 1'b0);
    write_burst(32'h147, 5'd1, 32'hF000_0000, 64'h0000_0000_0000_000F, -1, 1'b0);
    read_burst(32'h140, 5'd1);

    // Wrap from DEPTH-1 to 0,1 with an idle gap inside the write burst
    write_burst(32'(DEPTH - 1) << 6, 5'd3, 32'hC000_0000, '1, 0, 1'b0);
    read_burst(32'(DEPTH - 1) << 6, 5'd3);
    check_output("err_clean", word_t'(protocol_err), word_t'(0));

    // Read+write together, then bc=0 and bc=20 treated as single beats
    write_burst(32'(10) << 6, 5'd1, 32'h1000_0000, '1, -1, 1'b1);
    check_output("err_rw_collision", word_t'(protocol_err), word_t'(1));
    write_burst(32'(11) << 6, 5'd0, 32'h1100_0000, '1, -1, 1'b0);
    read_burst(32'(10) << 6, 5'd20);
    read_burst(32'(11) << 6, 5'd1);
    check_output("err_sticky", word_t'(protocol_err), word_t'(1));

    // Reset during an 8-beat read after three beats have been issued
    repeat (4) @(negedge clock);
    @(negedge clock);
    avs_read = 1'b1; avs_address = 32'h0; avs_burstcount = 5'd8;
    c = cyc;
    for (int k = 0; k < 2; k++) begin
      e.data = model[k];
      e.cycle = c + k + RD_LAT;
      rd_q.push_back(e);
    end
    @(negedge clock);
    avs_read = 1'b0;
    @(negedge clock);
    @(negedge clock);
    #1 reset = 1'b1;
    #1 check_reset_outputs("mid_reset");
    check_output("mid_reset_err", word_t'(protocol_err), word_t'(0));
    repeat (2) begin
      @(negedge clock);
      check_output("mid_reset_hold_rdv", word_t'(avs_readdatavalid), word_t'(0));
    end
    #1 reset = 1'b0;
    @(negedge clock);
    check_output("rel_waitrequest", word_t'(avs_waitrequest), word_t'(0));
    check_output("rel_busy", word_t'(busy), word_t'(0));
    repeat (6) @(negedge clock);
    read_burst(32'h0, 5'd2);

    for (int i = 0; i < 50; i++) begin
      if (rd_q.size() == 0 && ack_q.size() == 0) break;
      @(negedge clock);
    end
    check_output("drain_rd_pending", word_t'(rd_q.size()), word_t'(0));
    check_output("drain_ack_pending", word_t'(ack_q.size()), word_t'(0));
    @(negedge clock);
    check_output("final_busy", word_t'(busy), word_t'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
